// File: rtl/vga_capture.sv
// vga_capture: recovers the pixel raster position of a sampled VGA stream and
// writes the active region into a linear framebuffer.
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   pixel_en             pixel strobe; a rising clk edge with pixel_en=1 is a sample
//   hsync_n, vsync_n     active-low syncs, acted on only at samples
//   pixel_in             pixel data captured at a sample
//   col, row             recovered position of the last sample
//   locked               high while tracking a fully aligned raster
//   wr_en/wr_addr/wr_data  one-cycle framebuffer write, address row*H_ACTIVE+col
//   frame_start          pulses together with the write of pixel (0,0)
//   sync_err             pulses the cycle after a sample that broke sync timing
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_en,
  input  logic              hsync_n,
  input  logic              vsync_n,
  input  logic [DATA_W-1:0] pixel_in,
  output logic [9:0]        col,
  output logic [9:0]        row,
  output logic              locked,
  output logic              wr_en,
  output logic [19:0]       wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_start,
  output logic              sync_err
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_EDGE_COL = 10'(H_ACTIVE + H_FP);      // column of the hsync fall
  localparam logic [9:0] H_EDGE_PRE = 10'(H_ACTIVE + H_FP - 1);  // column just before it
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_EDGE_ROW = 10'(V_ACTIVE + V_FP);      // row of the vsync fall
  localparam logic [9:0] V_LATE_ROW = 10'(V_ACTIVE + V_FP + 1);  // vsync must be seen before here
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, H_ALIGN, LOCKED} state_t;

  state_t     state, state_n;
  logic       prev_h, prev_v;
  logic       v_seen, v_seen_n;  // a vsync edge already happened in the vsync row
  logic       h_edge, v_edge, col_wrap;
  logic       h_viol, v_viol, viol, wr_n;
  logic [9:0] col_nat, row_nat, col_n, row_n;

  always_comb begin
    h_edge   = prev_h & ~hsync_n;
    v_edge   = prev_v & ~vsync_n;
    col_wrap = !h_edge && (col == H_LAST);
    col_nat  = h_edge ? H_EDGE_COL : (col_wrap ? 10'd0 : col + 10'd1);
    row_nat  = !col_wrap ? row : ((row == V_LAST) ? 10'd0 : row + 10'd1);

    // Once aligned, the hsync edge must land exactly after H_EDGE_PRE.
    h_viol = (state != SEARCH) && (h_edge ? (col != H_EDGE_PRE) : (col == H_EDGE_PRE));
    // v_seen is only ever set while row sits on V_EDGE_ROW, so it is stale-free here.
    v_viol = (state == LOCKED) &&
             ((v_edge && ((row_nat != V_EDGE_ROW) || v_seen)) ||
              (col_wrap && (row_nat == V_LATE_ROW) && !v_seen));
    viol   = h_viol | v_viol;

    state_n  = state;
    col_n    = col_nat;
    row_n    = row_nat;
    v_seen_n = 1'b0;
    if (viol) begin
      // A violating sample that is itself an hsync edge still gives horizontal alignment.
      state_n = h_edge ? H_ALIGN : SEARCH;
      col_n   = h_edge ? H_EDGE_COL : 10'd0;
      row_n   = 10'd0;
    end else begin
      case (state)
        SEARCH:  if (h_edge) begin
                   state_n = H_ALIGN;
                   row_n   = 10'd0;
                 end
        H_ALIGN: if (v_edge) begin
                   state_n  = LOCKED;
                   row_n    = V_EDGE_ROW;
                   v_seen_n = 1'b1;
                 end
        LOCKED:  v_seen_n = (row_nat == V_EDGE_ROW) && (v_seen || v_edge);
        default: state_n = SEARCH;
      endcase
    end

    // Only a sample that starts and stays in LOCKED writes.
    wr_n = (state == LOCKED) && !viol && (col_nat < H_ACT) && (row_nat < V_ACT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      prev_h      <= 1'b1;
      prev_v      <= 1'b1;
      v_seen      <= 1'b0;
      col         <= '0;
      row         <= '0;
      locked      <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      if (pixel_en) begin
        prev_h   <= hsync_n;
        prev_v   <= vsync_n;
        state    <= state_n;
        col      <= col_n;
        row      <= row_n;
        v_seen   <= v_seen_n;
        locked   <= (state_n == LOCKED);
        sync_err <= viol;
        if (wr_n) begin
          wr_en   <= 1'b1;
          wr_data <= pixel_in;
          // Raster order makes the address a plain counter restarted at (0,0).
          if (col_n == 10'd0 && row_n == 10'd0) begin
            wr_addr     <= '0;
            frame_start <= 1'b1;
          end else begin
            wr_addr <= wr_addr + 20'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a shrunk raster (16x12 total, 8x6 active).
module tb_vga_capture;
  localparam int HA = 8, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 6, VFP = 2, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int HS0 = HA + HFP;
  localparam int VS0 = VA + VFP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst, pixel_en, hsync_n, vsync_n;
  logic [7:0]  pixel_in;
  logic [9:0]  col, row;
  logic        locked, wr_en, frame_start, sync_err;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  vga_capture #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .DATA_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .pixel_in(pixel_in), .col(col), .row(row), .locked(locked), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_start(frame_start), .sync_err(sync_err)
  );

  typedef struct packed {logic [19:0] addr; logic [7:0] data; logic fs;} wr_t;
  typedef struct {logic en, hs, vs; int ecol, erow; logic elk, eerr;} vec_t;

  wr_t sbq[$];
  int  checks = 0, errors = 0, err_cnt = 0, wr_cnt = 0, fs_cnt = 0;

  // stream generator position (next sample) and expectation state
  int   tr, tc;
  logic gph, gpv;
  bit   h_seen, lockexp, armed, rand_gap;
  int   force_h = -1, force_v = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // write scoreboard and pulse counters
  always @(negedge clk) begin
    wr_t e;
    if (wr_en) begin
      wr_cnt++;
      if (frame_start) fs_cnt++;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual addr=%0d required none", wr_addr);
      end else begin
        e = sbq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end else if (frame_start) begin
      checks++; errors++;
      $display("FAIL frame_start_without_write actual=1 required=0");
    end
    if (sync_err) err_cnt++;
  end

  // One sample of the generated stream; viol marks a sample the DUT must reject.
  task automatic step(input bit viol);
    logic hs, vs, he, ve;
    logic [7:0] pix;
    int gap;
    hs = !(tc >= HS0 && tc < HS0 + HSY);
    vs = !(tr >= VS0 && tr < VS0 + VSY);
    if (force_h >= 0) hs = force_h[0];
    if (force_v >= 0) vs = force_v[0];
    he  = gph & ~hs;
    ve  = gpv & ~vs;
    pix = 8'(tr * HA + tc);
    if (viol) begin
      armed = 0; lockexp = 0; h_seen = he;
    end else begin
      if (tr == 0 && tc == 0 && lockexp) armed = 1;
      if (ve && h_seen && !lockexp) lockexp = 1;
      if (he) h_seen = 1;
    end
    if (armed && !viol && tc < HA && tr < VA)
      sbq.push_back('{addr: 20'(tr * HA + tc), data: pix, fs: (tr == 0 && tc == 0)});
    hsync_n = hs; vsync_n = vs; pixel_in = pix; pixel_en = 1'b1;
    gph = hs; gpv = vs;
    @(posedge clk);
    @(negedge clk);
    pixel_en = 1'b0;
    chk("locked", 32'(locked), 32'(lockexp));
    chk("sync_err", 32'(sync_err), 32'(viol));
    if (h_seen)  chk("col", 32'(col), 32'(tc));
    if (lockexp) chk("row", 32'(row), 32'(tr));
    tc++;
    if (tc == HT) begin tc = 0; tr = (tr + 1) % VT; end
    gap = rand_gap ? int'($urandom_range(1, 4)) : 4;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic goto(input int r, input int c);
    int n = 0;
    do begin step(0); n++; end while (!(tr == r && tc == c) && n < 2 * FRAME);
    if (!(tr == r && tc == c)) begin
      checks++; errors++;
      $display("FAIL goto_bound actual=%0d,%0d required=%0d,%0d", tr, tc, r, c);
    end
  endtask

  // Run until a frame boundary that the model expects locked, then verify one full frame.
  task automatic relock_and_check();
    int k = 0;
    int w0, f0;
    do begin goto(0, 0); k++; end while (!lockexp && k < 4);
    chk("locked_at_frame", 32'(locked), 32'd1);
    w0 = wr_cnt; f0 = fs_cnt;
    repeat (FRAME) step(0);
    chk("frame_writes", 32'(wr_cnt - w0), 32'(HA * VA));
    chk("frame_starts", 32'(fs_cnt - f0), 32'd1);
    chk("queue_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_col"}, 32'(col), 0);
    chk({nm, "_row"}, 32'(row), 0);
    chk({nm, "_locked"}, 32'(locked), 0);
    chk({nm, "_wr_en"}, 32'(wr_en), 0);
    chk({nm, "_wr_addr"}, 32'(wr_addr), 0);
    chk({nm, "_wr_data"}, 32'(wr_data), 0);
    chk({nm, "_frame_start"}, 32'(frame_start), 0);
    chk({nm, "_sync_err"}, 32'(sync_err), 0);
  endtask

  initial begin
    vec_t tbl[13];
    // en hs vs | col row locked err   (from reset: SEARCH, col 0, row 0)
    tbl[0]  = '{1, 1, 1,  1,   0, 0, 0};
    tbl[1]  = '{0, 0, 0,  1,   0, 0, 0};        // no sample: everything holds
    tbl[2]  = '{1, 1, 0,  2,   0, 0, 0};        // vsync edge ignored in SEARCH
    tbl[3]  = '{1, 1, 1,  3,   0, 0, 0};
    tbl[4]  = '{1, 0, 1,  HS0, 0, 0, 0};        // hsync edge -> H_ALIGN
    tbl[5]  = '{1, 0, 1,  HS0 + 1, 0, 0, 0};
    tbl[6]  = '{1, 1, 1,  HS0 + 2, 0, 0, 0};
    tbl[7]  = '{1, 1, 0,  HS0 + 3, VS0, 1, 0};  // vsync edge -> LOCKED
    tbl[8]  = '{1, 1, 0,  HS0 + 4, VS0, 1, 0};
    tbl[9]  = '{1, 1, 1,  HS0 + 5, VS0, 1, 0};
    tbl[10] = '{1, 1, 1,  0, VS0 + 1, 1, 0};    // edge already seen: row VS0+1 legal
    tbl[11] = '{1, 1, 0,  0, 0, 0, 1};          // vsync edge in wrong row
    tbl[12] = '{1, 1, 1,  1, 0, 0, 0};

    rst = 1'b1; pixel_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; pixel_in = '0;
    rand_gap = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      hsync_n = tbl[i].hs; vsync_n = tbl[i].vs; pixel_en = tbl[i].en; pixel_in = 8'(i);
      @(posedge clk);
      @(negedge clk);
      pixel_en = 1'b0;
      chk($sformatf("tbl%0d_col", i), 32'(col), 32'(tbl[i].ecol));
      chk($sformatf("tbl%0d_row", i), 32'(row), 32'(tbl[i].erow));
      chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].elk));
      chk($sformatf("tbl%0d_sync_err", i), 32'(sync_err), 32'(tbl[i].eerr));
      repeat (3) @(negedge clk);
    end
    chk("tbl_err_count", 32'(err_cnt), 32'd1);

    // fresh start for the raster stream
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    hsync_n = 1'b1; vsync_n = 1'b1;
    tr = 0; tc = 0; gph = 1; gpv = 1; h_seen = 0; lockexp = 0; armed = 0;
    relock_and_check();
    rand_gap = 1;
    relock_and_check();
    rand_gap = 0;

    // early hsync edge inside the active line
    goto(2, 6); tc = HS0; step(1);
    chk("early_h_col", 32'(col), 32'(HS0));
    relock_and_check();

    // hsync missing for a whole line
    goto(3, HS0); force_h = 1; step(1);
    chk("miss_h_col", 32'(col), 0);
    chk("miss_h_row", 32'(row), 0);
    repeat (HSY - 1) step(0);
    force_h = -1;
    relock_and_check();

    // vsync edge in the wrong row
    goto(2, 3); force_v = 0; step(1); force_v = -1;
    chk("bad_v_col", 32'(col), 0);
    chk("bad_v_row", 32'(row), 0);
    relock_and_check();

    // vsync missing: error on reaching the row after the vsync row
    goto(VS0, 0); force_v = 1;
    repeat (HT) step(0);
    step(1);
    chk("miss_v_col", 32'(col), 0);
    chk("miss_v_row", 32'(row), 0);
    repeat (HT - 1) step(0);
    force_v = -1;
    relock_and_check();

    // H and V violation in the same sample: one pulse
    goto(2, 3); tc = HS0; force_v = 0; step(1); force_v = -1;
    relock_and_check();

    // asynchronous reset mid-frame
    goto(2, 3);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    h_seen = 0; lockexp = 0; armed = 0; gph = 1; gpv = 1;
    relock_and_check();

    chk("sync_err_total", 32'(err_cnt), 32'd6);
    chk("final_queue_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 (H_TOTAL 800); V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (V_TOTAL 525); DATA_W 8.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pixel_en  in  1  pixel strobe; a rising clk edge with pixel_en=1 is a "sample".
REQ-006 hsync_n  in  1  horizontal sync, active-low.
REQ-007 vsync_n  in  1  vertical sync, active-low.
REQ-008 pixel_in  in  DATA_W  pixel data, captured on a sample.
REQ-009 col  out  10  recovered column of the last sample, 0..799.
REQ-010 row  out  10  recovered row of the last sample, 0..524.
REQ-011 locked  out  1  high in LOCKED state.
REQ-012 wr_en  out  1  one-cycle framebuffer write strobe.
REQ-013 wr_addr  out  20  write address, row*640+col, 0..307199 (20'h4AFFF).
REQ-014 wr_data  out  DATA_W  pixel to write.
REQ-015 frame_start  out  1  one-cycle pulse on write of pixel (0,0).
REQ-016 sync_err  out  1  one-cycle pulse on sync violation.

Function
REQ-017 All inputs SHALL be acted on only at samples; between samples all state holds and pulse outputs are 0.
REQ-018 An hsync edge SHALL be hsync_n=1 at the previous sample and 0 at the current sample; a vsync edge likewise; previous-sample registers reset to 1.
REQ-019 Column update per sample: hsync edge -> col=656; otherwise col+1, wrapping 799->0.
REQ-020 Row update: on col wrap 799->0, row+1, wrapping 524->0; on vsync edge (H_ALIGN) row=490.
REQ-021 States SHALL be SEARCH, H_ALIGN, LOCKED; reset state SEARCH.
REQ-022 SEARCH: hsync edge -> H_ALIGN with col=656, row=0; vsync ignored; no errors.
REQ-023 H_ALIGN: vsync edge -> LOCKED with row=490 (takes priority over row wrap in the same sample).
REQ-024 In H_ALIGN and LOCKED an hsync edge is legal only when pre-update col==655; an edge at any other col, or pre-update col==655 with no edge, is an H violation.
REQ-025 In LOCKED a vsync edge is legal only when post-update row==490 and no vsync edge has yet occurred in row 490; reaching row 491 without one is a V violation.
REQ-026 Any violation SHALL: go to SEARCH, pulse sync_err the following cycle, suppress wr_en for that sample, and reset col/row to 0 (unless the violating sample is itself an hsync edge, in which case go to H_ALIGN with col=656, row=0).
REQ-027 Simultaneous H and V violation SHALL produce a single sync_err pulse.
REQ-028 Write: sample in LOCKED with post-update col<640 and row<480 SHALL assert wr_en for exactly one cycle, registered at that sample edge (1-cycle latency), with wr_data=pixel_in of that sample and wr_addr=row*640+col.
REQ-029 wr_addr SHALL be produced by an incrementing counter cleared at pixel (0,0), not a multiplier; it SHALL hold between writes.
REQ-030 frame_start SHALL assert in the same cycle as the wr_en for pixel (0,0).
REQ-031 No writes SHALL occur in SEARCH or H_ALIGN, including the sample that enters LOCKED.

Reset
REQ-032 rst=1 SHALL immediately force: state SEARCH; col, row, wr_addr, wr_data = 0; locked, wr_en, frame_start, sync_err = 0; sync history = 1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; relock requires a new hsync then vsync edge.

Verification
REQ-034 Standard 800x525 stream with pixel_en every 4th clk, vsync low in rows 490-491 -> locked rises within one frame; then 307200 wr_en per frame, wr_addr 0..307199 in order, one frame_start per frame.
REQ-035 Locked; hsync edge when pre-update col=600 -> sync_err one pulse, locked=0, col=656, state H_ALIGN, no further writes until next vsync edge.
REQ-036 Locked; hsync held high through col 655 -> sync_err at that sample, locked=0, col=0, row=0.
REQ-037 Locked; vsync edge at row 200 -> sync_err, SEARCH; vsync missing -> sync_err on entering row 491.
REQ-038 rst pulsed at row 100 col 300 -> all outputs 0 asynchronously; locked only after subsequent hsync and vsync edges.
REQ-039 pixel_in = low 8 bits of (row*640+col) -> every write has wr_data == wr_addr[7:0]; no wr_en for col>=640 or row>=480.
